// File: rtl/servo_pkg.sv
// Shared constants, types and helpers for the servo pulse capture peripheral.
package servo_pkg;

  localparam int unsigned CNT_W         = 26;
  localparam int unsigned SEL_MIN_UNITS = 10;
  localparam int unsigned SEL_MAX       = 10;

  localparam logic [1:0] REG_STATUS = 2'd0;
  localparam logic [1:0] REG_WIDTH  = 2'd1;
  localparam logic [1:0] REG_PERIOD = 2'd2;
  localparam logic [1:0] REG_UNITS  = 2'd3;

  // Flags occupy STATUS[11:8]; indices below are relative to FLAG_LSB.
  localparam int unsigned FLAG_LSB   = 8;
  localparam int unsigned FLAG_VALID = 0;
  localparam int unsigned FLAG_ERR   = 1;
  localparam int unsigned FLAG_LOST  = 2;
  localparam int unsigned FLAG_OVR   = 3;

  typedef enum logic [1:0] {
    WAIT_RISE = 2'd0,
    HIGH      = 2'd1,
    LOW       = 2'd2
  } cap_state_t;

  function automatic int unsigned STEP(input int unsigned basetime);
    return basetime / 10000;
  endfunction

  function automatic int unsigned MS(input int unsigned basetime);
    return basetime / 1000;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/servo_capture_if.sv
// SoC memory-bus slave port of the servo capture peripheral.
interface servo_capture_if;
  logic [31:0] address_in;
  logic        sel_in;
  logic        read_in;
  logic [31:0] read_value_out;
  logic [3:0]  write_mask_in;
  logic [31:0] write_value_in;
  logic        ready_out;

  modport master (
    output address_in, sel_in, read_in, write_mask_in, write_value_in,
    input  read_value_out, ready_out
  );

  modport slave (
    input  address_in, sel_in, read_in, write_mask_in, write_value_in,
    output read_value_out, ready_out
  );
endinterface

// File: rtl/servo_capture_pulse_sync_edge.sv
// Two-flop synchronizer with rise/fall strobes, armed only after a real low level is seen.
module pulse_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic level,
  output logic rise_c,
  output logic fall_c
);
  logic       meta;
  logic       sync;
  logic       prev;
  logic       armed;
  logic [1:0] fill;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta  <= 1'b0;
      sync  <= 1'b0;
      prev  <= 1'b0;
      fill  <= 2'b00;
      armed <= 1'b0;
    end else begin
      meta  <= async_in;
      sync  <= meta;
      prev  <= sync;
      fill  <= {fill[0], 1'b1};
      // A line already high at reset must not produce a rise for a truncated pulse.
      armed <= armed | (fill[1] & ~sync);
    end
  end

  assign level  = sync;
  assign rise_c = armed & sync & ~prev;
  assign fall_c = armed & ~sync & prev;
endmodule

// File: rtl/servo_capture.sv
// Servo pulse-train decoder: measures width/period, decodes selector 0..10, bus-readable.
module servo_capture
  import servo_pkg::*;
#(
  parameter int unsigned BASETIME   = 100000,
  parameter int unsigned TIMEOUT_MS = 40
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           pwm_in,
  output logic [7:0]     monitor,
  servo_capture_if.slave bus
);
  localparam int unsigned      STEP_CLKS  = STEP(BASETIME);
  localparam int unsigned      MS_CLKS    = MS(BASETIME);
  localparam logic [CNT_W-1:0] MAX_WIDTH  = CNT_W'(4 * MS_CLKS);
  localparam logic [CNT_W-1:0] LOST_CLKS  = CNT_W'(TIMEOUT_MS * MS_CLKS);
  localparam logic [CNT_W-1:0] PRESC_LOAD = CNT_W'(STEP_CLKS / 2);
  localparam logic [CNT_W-1:0] PRESC_LAST = CNT_W'(STEP_CLKS - 1);
  localparam logic [CNT_W-1:0] UNITS_LO   = CNT_W'(SEL_MIN_UNITS);
  localparam logic [CNT_W-1:0] UNITS_HI   = CNT_W'(SEL_MIN_UNITS + SEL_MAX);

  logic level, rise_c, fall_c;

  pulse_sync_edge u_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (pwm_in),
    .level    (level),
    .rise_c   (rise_c),
    .fall_c   (fall_c)
  );

  cap_state_t       state;
  logic [CNT_W-1:0] width_cnt, unit_cnt, presc, period_cnt, low_cnt;
  logic [CNT_W-1:0] width_reg, units_reg, period_reg;
  logic [7:0]       selector;
  logic [3:0]       flags;

  logic [CNT_W-1:0] width_nx, unit_nx;
  logic             too_long, capture, in_range, timeout, wr_status;
  logic [3:0]       flag_set, flag_clr;
  logic [31:0]      rd_mux;

  // Per-cycle measurement decisions and bus decode.
  always_comb begin
    width_nx  = sat_inc(width_cnt);
    unit_nx   = (presc == PRESC_LAST) ? sat_inc(unit_cnt) : unit_cnt;
    too_long  = (state == HIGH) && (width_nx > MAX_WIDTH);
    capture   = (state == HIGH) && fall_c && !too_long;
    in_range  = (unit_nx >= UNITS_LO) && (unit_nx <= UNITS_HI);
    timeout   = !level && (low_cnt == LOST_CLKS);

    flag_set             = '0;
    flag_set[FLAG_VALID] = capture & in_range;
    flag_set[FLAG_ERR]   = too_long | (capture & ~in_range);
    flag_set[FLAG_LOST]  = timeout;
    flag_set[FLAG_OVR]   = capture & flags[FLAG_VALID];

    wr_status = bus.sel_in && !bus.ready_out && !bus.read_in && bus.write_mask_in[1]
                && (bus.address_in[3:2] == REG_STATUS);
    flag_clr  = wr_status ? bus.write_value_in[FLAG_LSB +: 4] : 4'b0000;

    rd_mux = '0;
    case (bus.address_in[3:2])
      REG_STATUS: rd_mux = {20'd0, flags, selector};
      REG_WIDTH:  rd_mux = {6'd0, width_reg};
      REG_PERIOD: rd_mux = {6'd0, period_reg};
      REG_UNITS:  rd_mux = {6'd0, units_reg};
      default:    rd_mux = '0;
    endcase
  end

  // Capture FSM, result registers and bus response.
  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= WAIT_RISE;
      width_cnt          <= '0;
      unit_cnt           <= '0;
      presc              <= '0;
      period_cnt         <= '0;
      low_cnt            <= '0;
      width_reg          <= '0;
      units_reg          <= '0;
      period_reg         <= '0;
      selector           <= '0;
      flags              <= '0;
      bus.read_value_out <= '0;
      bus.ready_out      <= 1'b0;
    end else begin
      low_cnt    <= level ? '0 : sat_inc(low_cnt);
      period_cnt <= rise_c ? '0 : sat_inc(period_cnt);
      // Set beats a same-cycle write-1-to-clear.
      flags      <= (flags & ~flag_clr) | flag_set;

      if (flag_set[FLAG_VALID]) selector <= 8'(unit_nx - UNITS_LO);
      if (capture) begin
        width_reg <= width_nx;
        units_reg <= unit_nx;
      end

      case (state)
        WAIT_RISE: begin
          if (rise_c) begin
            state     <= HIGH;
            width_cnt <= '0;
            unit_cnt  <= '0;
            presc     <= PRESC_LOAD;
          end
        end
        HIGH: begin
          width_cnt <= width_nx;
          unit_cnt  <= unit_nx;
          presc     <= (presc == PRESC_LAST) ? '0 : presc + 1'b1;
          if (too_long)    state <= WAIT_RISE;
          else if (fall_c) state <= LOW;
        end
        LOW: begin
          if (rise_c) begin
            period_reg <= sat_inc(period_cnt);
            state      <= HIGH;
            width_cnt  <= '0;
            unit_cnt   <= '0;
            presc      <= PRESC_LOAD;
          end
        end
        default: state <= WAIT_RISE;
      endcase
      if (timeout) state <= WAIT_RISE;

      bus.ready_out      <= bus.sel_in & ~bus.ready_out;
      bus.read_value_out <= (bus.sel_in && bus.read_in) ? rd_mux : 32'd0;
    end
  end

  assign monitor = selector;

  logic unused_bus_bits;
  assign unused_bus_bits = ^{bus.address_in[31:4], bus.address_in[1:0],
                             bus.write_value_in[31:12], bus.write_value_in[7:0],
                             bus.write_mask_in[3:2], bus.write_mask_in[0]};
endmodule

// File: tb/tb_servo_capture.sv
// Directed bench for servo_capture: scoreboard of expected bus reads plus direct output checks.
module tb_servo_capture;
  logic       clk;
  logic       reset;
  logic       pwm_in;
  logic [7:0] monitor;
  int         cyc;
  int         next_rise;
  int         n_tests;
  int         n_fail;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;
  exp_t sb_q[$];

  servo_capture_if bus ();

  servo_capture #(.BASETIME(100000), .TIMEOUT_MS(40)) dut (
    .clk     (clk),
    .reset   (reset),
    .pwm_in  (pwm_in),
    .monitor (monitor),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every acknowledged read is matched against the oldest expectation.
  always @(negedge clk) begin
    if (bus.ready_out && bus.sel_in && bus.read_in) begin
      exp_t e;
      n_tests++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: read data 0x%08h with no expectation queued", bus.read_value_out);
      end else begin
        e = sb_q.pop_front();
        if (bus.read_value_out !== e.val) begin
          n_fail++;
          $display("FAIL %s: got 0x%08h, required 0x%08h", e.name, bus.read_value_out, e.val);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, expv);
    end
  endtask

  // Called just after a posedge; returns just after a posedge with the bus idle.
  task automatic bus_xfer(input logic rd, input logic [1:0] addr, input logic [31:0] wdata,
                          input logic [3:0] mask, input string name, input logic [31:0] expv);
    bit got;
    if (rd) sb_q.push_back('{name: name, val: expv});
    bus.address_in     = {28'd0, addr, 2'b00};
    bus.sel_in         = 1'b1;
    bus.read_in        = rd;
    bus.write_mask_in  = rd ? 4'b0000 : mask;
    bus.write_value_in = wdata;
    got = 1'b0;
    for (int i = 0; i < 16 && !got; i++) begin
      @(negedge clk);
      if (bus.ready_out) got = 1'b1;
    end
    if (!got) begin
      n_tests++;
      n_fail++;
      $display("FAIL bus_timeout %s: ready_out stayed 0 for 16 clk, required 1", name);
    end
    @(posedge clk);
    #1;
    bus.sel_in        = 1'b0;
    bus.read_in       = 1'b0;
    bus.write_mask_in = 4'b0000;
  endtask

  task automatic rd(input logic [1:0] addr, input string name, input logic [31:0] expv);
    bus_xfer(1'b1, addr, 32'd0, 4'b0000, name, expv);
  endtask

  task automatic clr_flags();
    bus_xfer(1'b0, 2'd0, 32'h0000_0F00, 4'b0010, "clr", 32'd0);
  endtask

  // One pulse of h clk high; next rising edge scheduled p clk after this one.
  task automatic frame(input int h, input int p, input bit w1c_at_capture);
    do begin @(posedge clk); #1; end while (cyc < next_rise);
    pwm_in    = 1'b1;
    next_rise = cyc + p;
    repeat (h) @(posedge clk);
    #1;
    pwm_in = 1'b0;
    if (w1c_at_capture) begin
      repeat (2) @(posedge clk);
      #1;
      clr_flags();
    end
    repeat (8) @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded 100000 clk");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    next_rise          = 0;
    reset              = 1'b1;
    pwm_in             = 1'b0;
    bus.address_in     = '0;
    bus.sel_in         = 1'b0;
    bus.read_in        = 1'b0;
    bus.write_mask_in  = '0;
    bus.write_value_in = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    check("rst_monitor", {24'd0, monitor}, 32'd0);
    check("rst_ready", {31'd0, bus.ready_out}, 32'd0);
    check("rst_rdata", bus.read_value_out, 32'd0);
    rd(2'd0, "rst_status", 32'd0);
    rd(2'd1, "rst_width", 32'd0);
    rd(2'd2, "rst_period", 32'd0);
    rd(2'd3, "rst_units", 32'd0);

    // 1.5 ms pulses at 2000 clk frame rate
    frame(150, 2000, 1'b0);
    rd(2'd0, "f1_status", 32'h0000_0105);
    check("f1_monitor", {24'd0, monitor}, 32'd5);
    rd(2'd1, "f1_width", 32'd150);
    rd(2'd3, "f1_units", 32'd15);
    rd(2'd2, "f1_period_first", 32'd0);
    frame(150, 2000, 1'b0);
    rd(2'd0, "f2_status_ovr", 32'h0000_0905);
    rd(2'd2, "f2_period", 32'd2000);
    rd(2'd1, "f2_width", 32'd150);
    clr_flags();
    rd(2'd0, "w1c_status", 32'h0000_0005);
    frame(150, 2000, 1'b0);
    rd(2'd0, "f3_status", 32'h0000_0105);

    // selector extremes
    frame(100, 2000, 1'b0);
    rd(2'd0, "sel0_status", 32'h0000_0900);
    rd(2'd1, "sel0_width", 32'd100);
    check("sel0_monitor", {24'd0, monitor}, 32'd0);
    clr_flags();
    frame(200, 2000, 1'b0);
    rd(2'd0, "sel10_status", 32'h0000_010A);
    rd(2'd1, "sel10_width", 32'd200);
    rd(2'd3, "sel10_units", 32'd20);
    check("sel10_monitor", {24'd0, monitor}, 32'd10);

    // out-of-range and rounding boundaries
    clr_flags();
    frame(250, 2000, 1'b0);
    rd(2'd0, "w250_status", 32'h0000_020A);
    rd(2'd3, "w250_units", 32'd25);
    clr_flags();
    frame(95, 2000, 1'b0);
    rd(2'd0, "w95_status", 32'h0000_0100);
    rd(2'd3, "w95_units", 32'd10);
    rd(2'd1, "w95_width", 32'd95);
    clr_flags();
    frame(450, 3000, 1'b0);
    rd(2'd0, "w450_status", 32'h0000_0200);
    rd(2'd1, "w450_width_kept", 32'd95);
    rd(2'd2, "w450_period", 32'd2000);
    frame(150, 2000, 1'b0);
    rd(2'd0, "after450_status", 32'h0000_0305);
    rd(2'd2, "after450_period_kept", 32'd2000);
    rd(2'd1, "after450_width", 32'd150);

    // signal loss, W1C mask handling, read-only registers
    repeat (4200) @(posedge clk);
    #1;
    rd(2'd0, "lost_status", 32'h0000_0705);
    bus_xfer(1'b0, 2'd0, 32'h0000_0F00, 4'b0001, "w1c_badmask", 32'd0);
    rd(2'd0, "badmask_status", 32'h0000_0705);
    clr_flags();
    rd(2'd0, "lost_clr_status", 32'h0000_0005);
    check("lost_clr_monitor", {24'd0, monitor}, 32'd5);
    bus_xfer(1'b0, 2'd1, 32'hFFFF_FFFF, 4'b1111, "wr_width", 32'd0);
    rd(2'd1, "ro_width", 32'd150);
    next_rise = 0;
    frame(120, 2500, 1'b0);
    rd(2'd0, "relock_status", 32'h0000_0102);
    rd(2'd2, "relock_period_kept", 32'd2000);
    rd(2'd3, "relock_units", 32'd12);
    frame(120, 2000, 1'b0);
    rd(2'd2, "relock_period", 32'd2500);
    rd(2'd0, "relock2_status", 32'h0000_0902);

    // W1C coinciding with a capture
    clr_flags();
    frame(120, 2000, 1'b0);
    rd(2'd0, "pre_race_status", 32'h0000_0102);
    frame(150, 2000, 1'b1);
    rd(2'd0, "race_status", 32'h0000_0905);

    // reset in the middle of a pulse
    do begin @(posedge clk); #1; end while (cyc < next_rise);
    pwm_in = 1'b1;
    repeat (60) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("midrst_monitor", {24'd0, monitor}, 32'd0);
    check("midrst_ready", {31'd0, bus.ready_out}, 32'd0);
    check("midrst_rdata", bus.read_value_out, 32'd0);
    rd(2'd0, "midrst_status", 32'd0);
    rd(2'd1, "midrst_width", 32'd0);
    repeat (80) @(posedge clk);
    #1;
    pwm_in = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    rd(2'd0, "trunc_status", 32'd0);
    rd(2'd3, "trunc_units", 32'd0);
    next_rise = cyc + 200;
    frame(120, 2000, 1'b0);
    rd(2'd0, "post_rst_status", 32'h0000_0102);
    rd(2'd1, "post_rst_width", 32'd120);
    rd(2'd3, "post_rst_units", 32'd12);
    rd(2'd2, "post_rst_period", 32'd0);
    check("post_rst_monitor", {24'd0, monitor}, 32'd2);

    repeat (5) @(posedge clk);
    #1;
    check("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
